// File: rtl/key_debounce_array_if.sv
// Key bank signal bundle: raw pad levels in, conditioned level and event pulses out.
// The conditioner takes the master view; whatever drives the pads and consumes events takes the slave view.
interface key_debounce_array_if #(
   parameter int CH_NUM = 4
);
   logic [CH_NUM-1:0] key_in;
   logic [CH_NUM-1:0] key_out;
   logic [CH_NUM-1:0] key_press;
   logic [CH_NUM-1:0] key_release;
   logic [CH_NUM-1:0] key_long;

   modport master (
      input  key_in,
      output key_out,
      output key_press,
      output key_release,
      output key_long
   );

   modport slave (
      output key_in,
      input  key_out,
      input  key_press,
      input  key_release,
      input  key_long
   );
endinterface

// File: rtl/key_debounce_array.sv
// Multi-channel key conditioner: synchronise, debounce, and emit one-cycle
// press / release / long-press pulses per channel. There is no handshake; pulses are fire-and-forget.
module key_debounce_array #(
   parameter int CH_NUM     = 4,
   parameter int CLK_CYC    = 10,
   parameter int DEB_NS     = 10_000_000,
   parameter int LONG_NS    = 1_000_000_000,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                   sysclk,
   input  logic                   sys_rst,
   key_debounce_array_if.master   keys
);

   localparam int DEB_CNT  = DEB_NS / CLK_CYC;
   localparam int LONG_CNT = LONG_NS / CLK_CYC;
   localparam int MAX_CNT  = (DEB_CNT > LONG_CNT) ? DEB_CNT : LONG_CNT;
   localparam int CW       = $clog2(MAX_CNT + 1);
   localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CNT);

   logic [CH_NUM-1:0] s0, s1, s2;
   logic [CH_NUM-1:0] trig;
   logic [CH_NUM-1:0] key_out_d;
   logic [CH_NUM-1:0] key_out_q;
   logic [CH_NUM-1:0] press_q;
   logic [CH_NUM-1:0] release_q;
   logic [CH_NUM-1:0] long_vec;

   // Inputs are normalised before the first flop so "pressed" is always 1 internally.
   always_ff @(posedge sysclk or posedge sys_rst) begin
      if (sys_rst) begin
         s0 <= '0;
         s1 <= '0;
         s2 <= '0;
      end else begin
         s0 <= keys.key_in ^ {CH_NUM{ACTIVE_LOW}};
         s1 <= s0;
         s2 <= s1;
      end
   end

   assign trig = s1 ^ s2;

   for (genvar i = 0; i < CH_NUM; i++) begin : g_deb
      logic [CW-1:0] deb_cnt;
      logic          deb_done;

      assign deb_done = (deb_cnt == DEB_MAX);

      always_ff @(posedge sysclk or posedge sys_rst) begin
         if (sys_rst) begin
            deb_cnt <= '0;
         end else if (trig[i]) begin
            deb_cnt <= '0;
         end else if (!deb_done) begin
            deb_cnt <= deb_cnt + CW'(1);
         end
      end

      assign key_out_d[i] = deb_done ? s2[i] : key_out_q[i];
   end

   always_ff @(posedge sysclk or posedge sys_rst) begin
      if (sys_rst) begin
         key_out_q <= '0;
         press_q   <= '0;
         release_q <= '0;
      end else begin
         key_out_q <= key_out_d;
         press_q   <= key_out_d & ~key_out_q;
         release_q <= ~key_out_d & key_out_q;
      end
   end

   if (LONG_CNT > 0) begin : g_long
      localparam logic [CW-1:0] LONG_MAX = CW'(LONG_CNT);
      localparam logic [CW-1:0] LONG_PRE = CW'(LONG_CNT - 1);

      for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
         logic [CW-1:0] hold_cnt;
         logic          long_r;

         // The pulse fires on the edge the counter reaches LONG_MAX; saturation blocks repeats.
         always_ff @(posedge sysclk or posedge sys_rst) begin
            if (sys_rst) begin
               hold_cnt <= '0;
               long_r   <= 1'b0;
            end else begin
               long_r <= key_out_q[i] && (hold_cnt == LONG_PRE);
               if (!key_out_q[i]) begin
                  hold_cnt <= '0;
               end else if (hold_cnt != LONG_MAX) begin
                  hold_cnt <= hold_cnt + CW'(1);
               end
            end
         end

         assign long_vec[i] = long_r;
      end
   end else begin : g_no_long
      assign long_vec = '0;
   end

   assign keys.key_out     = key_out_q;
   assign keys.key_press   = press_q;
   assign keys.key_release = release_q;
   assign keys.key_long    = long_vec;

endmodule

// File: doc/key_debounce_array.md
# key_debounce_array

Multi-channel, parametrised key conditioner for user-facing push-buttons and switches. Each channel synchronises a raw pad input, debounces it over a configurable stable time, and presents a clean level plus one-cycle press, release and long-press pulses. It sits between board pads and control logic, replacing per-key single-channel debouncers with one instance per key bank.

## Interface
- CH_NUM, 4, number of independent key channels (≥1)
- CLK_CYC, 10, sysclk period in ns
- DEB_NS, 10_000_000, required stable time in ns; DEB_CNT = DEB_NS/CLK_CYC, must be ≥1
- LONG_NS, 1_000_000_000, long-press threshold in ns; LONG_CNT = LONG_NS/CLK_CYC; 0 disables long-press
- ACTIVE_LOW, 1, 1: pad reads 0 when pressed; 0: pad reads 1 when pressed

- sysclk  input  1  system clock; all logic on rising edge
- sys_rst  input  1  asynchronous, active-high reset
- key_in  input  CH_NUM  raw pad levels, asynchronous to sysclk
- key_out  output  CH_NUM  debounced level, normalised: 1 = pressed
- key_press  output  CH_NUM  one-cycle pulse on debounced press
- key_release  output  CH_NUM  one-cycle pulse on debounced release
- key_long  output  CH_NUM  one-cycle pulse when press held LONG_CNT cycles

## Operation
- Per channel: 3-flop chain s0→s1→s2 on key_in XOR-normalised by ACTIVE_LOW (pressed = 1 internally); s0/s1 are the synchroniser, s2 the edge reference.
- trig = s1 ^ s2 (combinational).
- Debounce counter: trig=1 → 0; else if == DEB_CNT → hold; else +1.
- key_out registered: loads s2 on edges where counter == DEB_CNT; otherwise holds.
- key_press = 1 for one cycle in the cycle key_out goes 0→1; key_release likewise for 1→0. All three registered, updated on the same edge.
- Hold counter: cleared while key_out=0; increments each edge while key_out=1, saturating at LONG_CNT. key_long pulses for one cycle on the edge the counter becomes LONG_CNT; no repeat until release and re-press.
- LONG_NS=0: hold counter omitted, key_long tied 0.
- Counter width: $clog2(max(DEB_CNT, LONG_CNT)+1); no wrap-around anywhere, counters saturate.
- Channels fully independent; simultaneous events on several channels each produce their own pulses in the same cycle.
- Reset (async, any time): s0/s1/s2 = 0 (released after normalisation), both counters = 0, key_out = 0, key_press/key_release/key_long = 0. No pulse is generated by reset assertion or deassertion itself.

## Timing
- Pad level change sampled into s0 at edge 0: trig high between edges 1 and 2; debounce counter = 0 at edge 2; reaches DEB_CNT at edge 2+DEB_CNT; key_out and press/release pulse update at edge 3+DEB_CNT. Latency = DEB_CNT+3 cycles.
- Any pad toggle before that point restarts the sequence from the new edge; bounces shorter than DEB_CNT cycles of stability never reach key_out.
- key_long asserts LONG_CNT cycles after key_out rose (edge 3+DEB_CNT+LONG_CNT from first sample).
- Release before LONG_CNT: no key_long; key_release still pulses.
- Press held through reset deassertion: treated as new press; key_out rises DEB_CNT+3 cycles after first post-reset sample.

## Test plan
Bench parameters: CH_NUM=4, CLK_CYC=10, DEB_NS=100 (DEB_CNT=10), LONG_NS=500 (LONG_CNT=50), ACTIVE_LOW=1.
- Clean press: key_in[0] 1→0 sampled at edge 0, held -> key_out[0]=1 and key_press[0]=1 for exactly one cycle at edge 13; other channels stay 0.
- Bounce rejection: key_in[1] toggles every 5 cycles for 40 cycles then settles low -> no output activity during bouncing; key_out[1] rises 13 cycles after final toggle sample; exactly one key_press[1].
- Long press: key_in[2] held pressed 100 cycles -> key_press[2] at edge 13, single key_long[2] at edge 63, none after; release -> key_release[2] 13 cycles after release sample.
- Short press: key_in[3] pressed 30 cycles -> key_press[3] and key_release[3] pulses, key_long[3] never asserts.
- Simultaneous channels: all four keys pressed on the same edge -> key_press=4'b1111 for one cycle at edge 13.
- Reset mid-operation: sys_rst asserted at cycle 40 of a held press -> key_out and all pulses 0 immediately, no release pulse; after deassert with key still held, key_press reasserts 13 cycles after first sample.
